// File: rtl/match_scheduler.sv
// Best-of-ROUNDS turn/round sequencer: pulses the game core reset, times turns, keeps score.
// Outputs settle one edge after the triggering input (timeout is same-cycle); no backpressure, inputs sampled every cycle.
module match_scheduler #(
    parameter int ROUNDS      = 3,
    parameter int TURN_CYCLES = 50000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       p1_win,
    input  logic       p2_win,
    input  logic       guess_ev,
    output logic       game_reset,
    output logic       turn_owner,
    output logic       timeout,
    output logic [2:0] score1,
    output logic [2:0] score2,
    output logic [2:0] round_cnt,
    output logic       match_over,
    output logic [1:0] match_winner
);

    localparam int              TW         = (TURN_CYCLES > 2) ? $clog2(TURN_CYCLES) : 1;
    localparam logic [TW-1:0]   T_LAST     = TW'(TURN_CYCLES - 1);
    localparam logic [2:0]      MAJORITY   = 3'(ROUNDS / 2);
    localparam logic [2:0]      LAST_ROUND = 3'(ROUNDS - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CORE_RST  = 3'd1,
        PLAY      = 3'd2,
        ROUND_END = 3'd3,
        DONE      = 3'd4
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            rst_phase;
    logic [TW-1:0]   timer;
    logic            any_win;
    logic            turn_end;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        game_reset   = 1'b0;
        timeout      = 1'b0;
        match_over   = 1'b0;
        match_winner = 2'b00;
        turn_end     = 1'b0;
        any_win      = p1_win | p2_win;
        case (state)
            IDLE: begin
                if (start) state_nxt = CORE_RST;
            end
            CORE_RST: begin
                game_reset = 1'b1;
                if (rst_phase) state_nxt = PLAY;
            end
            PLAY: begin
                // A win outranks a guess, and a guess outranks turn expiry.
                if (any_win) begin
                    state_nxt = ROUND_END;
                end else if (guess_ev) begin
                    turn_end = 1'b1;
                end else if (timer == T_LAST) begin
                    turn_end = 1'b1;
                    timeout  = 1'b1;
                end
            end
            ROUND_END: begin
                if (score1 > MAJORITY || score2 > MAJORITY || round_cnt == LAST_ROUND)
                    state_nxt = DONE;
                else
                    state_nxt = CORE_RST;
            end
            DONE: begin
                match_over = 1'b1;
                if (score1 > score2)      match_winner = 2'b01;
                else if (score2 > score1) match_winner = 2'b10;
                else                      match_winner = 2'b11;
                if (start) state_nxt = CORE_RST;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rst_phase  <= 1'b0;
            timer      <= '0;
            turn_owner <= 1'b0;
            score1     <= 3'd0;
            score2     <= 3'd0;
            round_cnt  <= 3'd0;
        end else begin
            // Second CORE_RST cycle is marked by rst_phase; it is zero on every entry.
            rst_phase <= (state == CORE_RST) && !rst_phase;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        score1     <= 3'd0;
                        score2     <= 3'd0;
                        round_cnt  <= 3'd0;
                        turn_owner <= 1'b0;
                    end
                end
                CORE_RST: begin
                    timer      <= '0;
                    turn_owner <= 1'b0;
                end
                PLAY: begin
                    if (any_win) begin
                        timer <= '0;
                        if (p1_win && !p2_win && score1 != 3'd7) score1 <= score1 + 3'd1;
                        if (p2_win && !p1_win && score2 != 3'd7) score2 <= score2 + 3'd1;
                    end else if (turn_end) begin
                        timer      <= '0;
                        turn_owner <= ~turn_owner;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ROUND_END: begin
                    if (round_cnt != 3'd7) round_cnt <= round_cnt + 3'd1;
                    if (state_nxt == CORE_RST) turn_owner <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_match_scheduler.sv
// Bench for match_scheduler (ROUNDS=3, TURN_CYCLES=8): directed scenarios then random play against a cycle model.
module tb_match_scheduler;

    localparam int R  = 3;
    localparam int TC = 8;

    localparam int M_IDLE = 0;
    localparam int M_CORE = 1;
    localparam int M_PLAY = 2;
    localparam int M_REND = 3;
    localparam int M_DONE = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       start, p1_win, p2_win, guess_ev;
    logic       game_reset, turn_owner, timeout, match_over;
    logic [2:0] score1, score2, round_cnt;
    logic [1:0] match_winner;

    match_scheduler #(.ROUNDS(R), .TURN_CYCLES(TC)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .p1_win       (p1_win),
        .p2_win       (p2_win),
        .guess_ev     (guess_ev),
        .game_reset   (game_reset),
        .turn_owner   (turn_owner),
        .timeout      (timeout),
        .score1       (score1),
        .score2       (score2),
        .round_cnt    (round_cnt),
        .match_over   (match_over),
        .match_winner (match_winner)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int gr_seen  = 0;
    int to_seen  = 0;

    // Reference: match phase, core-reset cycles left, turn holder, cycles into current turn, tallies.
    int m_mode, m_rc, m_age, m_s1, m_s2, m_rnd;
    bit m_turn;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_rc = 0; m_age = 0; m_s1 = 0; m_s2 = 0; m_rnd = 0; m_turn = 0;
    endtask

    task automatic model_new_round();
        m_mode = M_CORE; m_rc = 2; m_turn = 0; m_age = 0;
    endtask

    task automatic model_step(input bit s, input bit g, input bit a, input bit b);
        case (m_mode)
            M_IDLE, M_DONE: if (s) begin
                m_s1 = 0; m_s2 = 0; m_rnd = 0;
                model_new_round();
            end
            M_CORE: begin
                m_rc--;
                if (m_rc == 0) m_mode = M_PLAY;
            end
            M_PLAY: begin
                if (a || b) begin
                    if (a && !b) m_s1 = (m_s1 < 7) ? m_s1 + 1 : 7;
                    if (b && !a) m_s2 = (m_s2 < 7) ? m_s2 + 1 : 7;
                    m_mode = M_REND;
                end else if (g || m_age == TC - 1) begin
                    m_turn = !m_turn;
                    m_age  = 0;
                end else begin
                    m_age++;
                end
            end
            M_REND: begin
                m_rnd = (m_rnd < 7) ? m_rnd + 1 : 7;
                if (m_s1 > R / 2 || m_s2 > R / 2 || m_rnd == R) m_mode = M_DONE;
                else model_new_round();
            end
            default: m_mode = M_IDLE;
        endcase
    endtask

    task automatic check_outputs(input bit g, input bit a, input bit b);
        bit       exp_to;
        bit [1:0] exp_w;
        exp_to = (m_mode == M_PLAY) && (m_age == TC - 1) && !g && !(a || b);
        exp_w  = 2'b00;
        if (m_mode == M_DONE) exp_w = (m_s1 > m_s2) ? 2'b01 : (m_s2 > m_s1) ? 2'b10 : 2'b11;
        chk("game_reset", game_reset, 8'(m_mode == M_CORE));
        chk("turn_owner", turn_owner, 8'(m_turn));
        chk("timeout", timeout, 8'(exp_to));
        chk("score1", score1, 8'(m_s1));
        chk("score2", score2, 8'(m_s2));
        chk("round_cnt", round_cnt, 8'(m_rnd));
        chk("match_over", match_over, 8'(m_mode == M_DONE));
        chk("match_winner", match_winner, 8'(exp_w));
        if (game_reset === 1'b1) gr_seen++;
        if (timeout === 1'b1) to_seen++;
    endtask

    // Entered and left at 1 time unit after a rising edge.
    task automatic tick(input bit s, input bit g, input bit a, input bit b);
        start = s; guess_ev = g; p1_win = a; p2_win = b;
        @(negedge clock);
        check_outputs(g, a, b);
        @(posedge clock);
        model_step(s, g, a, b);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(0, 0, 0, 0);
    endtask

    task automatic to_play();
        for (int k = 0; k < 8 && m_mode != M_PLAY; k++) tick(0, 0, 0, 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_game_reset"}, game_reset, 8'd0);
        chk({tag, "_turn_owner"}, turn_owner, 8'd0);
        chk({tag, "_timeout"}, timeout, 8'd0);
        chk({tag, "_score1"}, score1, 8'd0);
        chk({tag, "_score2"}, score2, 8'd0);
        chk({tag, "_round_cnt"}, round_cnt, 8'd0);
        chk({tag, "_match_over"}, match_over, 8'd0);
        chk({tag, "_match_winner"}, match_winner, 8'd0);
    endtask

    initial begin
        int to_before;
        reset = 1'b1; start = 0; guess_ev = 0; p1_win = 0; p2_win = 0;
        model_reset();
        #2;
        check_all_zero("por");
        @(posedge clock); #1;
        reset = 1'b0;

        // Core reset lasts two cycles, then three guesses alternate the turn.
        gr_seen = 0;
        tick(1, 0, 0, 0);
        to_play();
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 0, 0);
            tick(0, 1, 0, 0);
            chk("turn_seq", turn_owner, 8'(i % 2 == 0));
        end
        chk("game_reset_cycles", 8'(gr_seen), 8'd2);

        // Silent turn expires on its 8th cycle; a guess on that cycle suppresses the timeout.
        to_seen = 0;
        idle(TC);
        chk("timeout_once", 8'(to_seen), 8'd1);
        chk("turn_after_timeout", turn_owner, 8'd0);
        idle(TC - 1);
        tick(0, 1, 0, 0);
        chk("guess_at_expiry_no_timeout", 8'(to_seen), 8'd1);
        chk("guess_at_expiry_turn", turn_owner, 8'd1);

        // P1 wins two straight rounds.
        tick(0, 0, 1, 0);
        tick(0, 0, 1, 0);
        to_play();
        tick(0, 0, 1, 0);
        tick(0, 0, 0, 0);
        chk("p1_match_score1", score1, 8'd2);
        chk("p1_match_rounds", round_cnt, 8'd2);
        chk("p1_match_over", match_over, 8'd1);
        chk("p1_match_winner", match_winner, 8'd1);

        // P1, then P2 on a guess+expiry cycle, then a drawn round.
        tick(1, 0, 0, 0);
        chk("restart_score1", score1, 8'd0);
        to_play();
        tick(0, 0, 1, 0);
        tick(0, 0, 0, 0);
        to_play();
        idle(TC - 1);
        to_before = to_seen;
        tick(0, 1, 0, 1);
        chk("p2_win_score2", score2, 8'd1);
        chk("p2_win_turn", turn_owner, 8'd0);
        chk("p2_win_no_timeout", 8'(to_seen), 8'(to_before));
        tick(0, 0, 0, 0);
        to_play();
        tick(0, 0, 1, 1);
        tick(0, 0, 0, 0);
        chk("draw_score1", score1, 8'd1);
        chk("draw_score2", score2, 8'd1);
        chk("draw_rounds", round_cnt, 8'd3);
        chk("draw_winner", match_winner, 8'd3);

        // Reset mid-play after P2 took a round.
        tick(1, 0, 0, 0);
        to_play();
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 0);
        to_play();
        idle(3);
        chk("pre_reset_score2", score2, 8'd1);
        reset = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(posedge clock); #1;
        reset = 1'b0;
        model_reset();
        idle(2);
        tick(1, 0, 0, 0);
        to_play();
        chk("post_reset_score1", score1, 8'd0);
        chk("post_reset_score2", score2, 8'd0);

        // Random play checked cycle by cycle against the model.
        for (int i = 0; i < 600; i++) begin
            tick($urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/match_scheduler.md
MATCH_SCHEDULER -- requirements
Module: match_scheduler

Interface
REQ-001 SHALL provide parameter ROUNDS, default 3, the number of rounds in a best-of-N match (odd, 1..7).
REQ-002 SHALL provide parameter TURN_CYCLES, default 50000000, the clock cycles allowed per turn before timeout (>=2).
REQ-003 SHALL have port clock, input, 1, the single system clock; all state changes occur on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1, single-cycle pulse that begins a match.
REQ-006 SHALL have ports p1_win and p2_win, input, 1 each, level win flags from the game core, held until the core is reset.
REQ-007 SHALL have port guess_ev, input, 1, single-cycle pulse marking a confirmed guess that ends the current turn.
REQ-008 SHALL have port game_reset, output, 1, reset request to the game core.
REQ-009 SHALL have port turn_owner, output, 1, the player to move: 0 = P1, 1 = P2.
REQ-010 SHALL have port timeout, output, 1, single-cycle pulse when a turn expires.
REQ-011 SHALL have ports score1 and score2, output, 3 each, rounds won by P1 and P2.
REQ-012 SHALL have port round_cnt, output, 3, the number of completed rounds.
REQ-013 SHALL have port match_over, output, 1, high while the match is decided.
REQ-014 SHALL have port match_winner, output, 2, the match result: 00 = none, 01 = P1, 10 = P2, 11 = draw.

Function
REQ-015 SHALL implement the FSM states IDLE, CORE_RST, PLAY, ROUND_END and DONE.
REQ-016 IDLE: on start, SHALL go to CORE_RST with scores and round_cnt cleared; all other inputs SHALL be ignored.
REQ-017 CORE_RST: SHALL assert game_reset for exactly 2 cycles, force turn_owner=0, clear the turn timer, then go to PLAY.
REQ-018 game_reset SHALL be low in all states except CORE_RST.
REQ-019 PLAY: the turn timer SHALL increment once per cycle.
REQ-020 PLAY, guess_ev=1: SHALL toggle turn_owner and clear the timer on the same edge.
REQ-021 PLAY, timer == TURN_CYCLES-1 with no guess_ev: SHALL pulse timeout for 1 cycle, toggle turn_owner and clear the timer.
REQ-022 PLAY, guess_ev and timer expiry in the same cycle: guess_ev SHALL win, timeout SHALL stay low, and turn_owner SHALL toggle once.
REQ-023 PLAY, p1_win or p2_win sampled high: SHALL go to ROUND_END next edge; a win SHALL override guess_ev and expiry in the same cycle (no toggle, no timeout).
REQ-024 On win entry: p1_win only SHALL increment score1; p2_win only SHALL increment score2; both high SHALL leave scores unchanged (drawn round); the update SHALL be visible in the first ROUND_END cycle.
REQ-025 ROUND_END: SHALL last 1 cycle and increment round_cnt.
REQ-026 ROUND_END: if either score > ROUNDS/2 (integer division) or round_cnt+1 == ROUNDS, SHALL go to DONE; otherwise SHALL go to CORE_RST.
REQ-027 DONE: SHALL hold match_over=1 and all counts frozen.
REQ-028 DONE, match_winner: 01 if score1>score2, 10 if score2>score1, 11 if equal.
REQ-029 DONE, on start: SHALL clear scores, round_cnt and match_winner and go to CORE_RST.
REQ-030 start SHALL be ignored in CORE_RST, PLAY and ROUND_END.
REQ-031 match_winner SHALL be 00 outside DONE.
REQ-032 The timer SHALL be $clog2(TURN_CYCLES) bits, SHALL not advance outside PLAY, and SHALL never exceed TURN_CYCLES-1.
REQ-033 Scores and round_cnt SHALL saturate at 7 and never wrap.

Reset
REQ-034 While reset is high, SHALL force state IDLE, all counters and the timer to 0, and every output to 0 (game_reset=0, turn_owner=0, timeout=0, match_over=0, match_winner=00) asynchronously.
REQ-035 Reset asserted mid-PLAY SHALL discard the match with no score retained; after deassertion SHALL wait in IDLE for start.

Verification (bench: ROUNDS=3, TURN_CYCLES=8)
REQ-036 start pulse -> game_reset high exactly 2 cycles, then PLAY with turn_owner=0; 3 guess_ev pulses -> turn_owner sequence 1,0,1.
REQ-037 No guess_ev for 8 PLAY cycles -> timeout pulses once on cycle 8, turn_owner toggles, timer restarts; guess_ev on the expiry cycle -> no timeout.
REQ-038 p1_win high in round 1 and round 2 -> score1=2, DONE after round 2 with round_cnt=2, match_over=1, match_winner=01.
REQ-039 Rounds P1 win, P2 win, then p1_win and p2_win both high -> scores 1/1, round_cnt=3, match_winner=11.
REQ-040 reset pulsed mid-PLAY with score2=1 -> all outputs 0 immediately; a later start begins with scores 0/0.
REQ-041 p2_win together with guess_ev and timer expiry -> score2 increments, no timeout, turn_owner unchanged.
